// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package pc_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HAVE  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and imem.
interface pc_fetch_unit_if #(parameter int XLEN = 32);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: sync reset, word-aligned load, increment by one instruction.
module pc_reg
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {load_val[XLEN-1:2], 2'b00};
    end else if (inc) begin
      pc <= pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and fetch stage: one outstanding imem request, one held instruction for decode.
//   state   | meaning
//   S_REQ   | request outstanding at pc, waiting for imem_ready
//   S_HAVE  | instruction held for decode, no request
//   S_DRAIN | branch taken mid-fetch; finish stale request, discard its data
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pcMux,
  input  logic [XLEN-1:0]        branch_target,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            inst,
  output logic [XLEN-1:0]        inst_pc,
  output logic                   inst_valid
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drain_tgt;
  logic            pc_load;
  logic            pc_inc;
  logic [XLEN-1:0] pc_load_val;

  pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign imem.imem_req  = !reset && (state != S_HAVE);
  assign imem.imem_addr = pc;

  always_comb begin
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = branch_target;
    case (state)
      S_REQ: begin
        if (pcMux && imem.imem_ready)       pc_load = 1'b1;
        else if (imem.imem_ready)           pc_inc  = 1'b1;
      end
      S_HAVE: begin
        if (!stall && pcMux)                pc_load = 1'b1;
      end
      S_DRAIN: begin
        // A fresh branch beats the latched one when the stale fetch completes.
        if (pcMux && imem.imem_ready) begin
          pc_load = 1'b1;
        end else if (imem.imem_ready) begin
          pc_load     = 1'b1;
          pc_load_val = drain_tgt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      drain_tgt  <= '0;
      inst       <= NOP_INSTR;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (pcMux) begin
            if (!imem.imem_ready) begin
              drain_tgt <= branch_target;
              state     <= S_DRAIN;
            end
          end else if (imem.imem_ready) begin
            inst       <= imem.imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HAVE;
          end
        end
        S_HAVE: begin
          if (!stall) begin
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (pcMux && !imem.imem_ready) drain_tgt <= branch_target;
          if (imem.imem_ready)           state     <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a fetch-stream model.
module tb_pc_fetch_unit;

  localparam logic [31:0] TAG = 32'h5A5A_5A5A;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        pcMux;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int n_vec;
  int n_err;

  // model: address being fetched, held instruction, pending redirect
  logic [31:0] m_pc;
  logic        m_hold;
  logic        m_redir;
  logic [31:0] m_rtgt;
  logic [31:0] m_inst;
  logic [31:0] m_inst_pc;

  pc_fetch_unit_if ifc ();

  assign ifc.imem_rdata = ifc.imem_addr ^ TAG;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pcMux         (pcMux),
    .branch_target (branch_target),
    .stall         (stall),
    .imem          (ifc),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, return at the next negedge.
  task automatic tick(input logic mux, input logic [31:0] tgt, input logic stl,
                      input logic rdy, input logic rst);
    pcMux          = mux;
    branch_target  = tgt;
    stall          = stl;
    ifc.imem_ready = rdy;
    reset          = rst;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_hold = 1'b0; m_redir = 1'b0; m_inst = NOP; m_inst_pc = 32'h0;
    end else if (m_hold) begin
      if (!stl) begin
        m_hold = 1'b0;
        if (mux) m_pc = align(tgt);
      end
    end else if (mux) begin
      if (rdy) begin m_pc = align(tgt); m_redir = 1'b0; end
      else     begin m_redir = 1'b1; m_rtgt = align(tgt); end
    end else if (rdy) begin
      if (m_redir) begin
        m_pc = m_rtgt; m_redir = 1'b0;
      end else begin
        m_inst = m_pc ^ TAG; m_inst_pc = m_pc; m_hold = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    pcMux = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", ifc.imem_req); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    n_vec++; if (inst !== NOP) begin n_err++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
    n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
    reset = 1'b0;
    #1;
    n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_first_req got=%b/%h exp=1/00000000", ifc.imem_req, ifc.imem_addr);
    end
  endtask

  task automatic test_zero_wait;
    test_reset();
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'(k * 2) || inst_valid !== 1'b0) begin
          n_err++; $display("FAIL zw_req k=%0d got=%b/%h/%b exp=1/%h/0", k, ifc.imem_req, ifc.imem_addr, inst_valid, 32'(k * 2));
        end
      end else begin
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'((k - 1) * 2) || inst !== (32'((k - 1) * 2) ^ TAG)) begin
          n_err++; $display("FAIL zw_inst k=%0d got=%b/%h/%h exp=1/%h", k, inst_valid, inst_pc, inst, 32'((k - 1) * 2));
        end
      end
      tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_delayed_ready;
    test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL dly_wait k=%0d got=%b/%h/%b exp=1/00000000/0", k, ifc.imem_req, ifc.imem_addr, inst_valid);
      end
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== TAG || ifc.imem_req !== 1'b0) begin
      n_err++; $display("FAIL dly_capture got=%b/%h/%h req=%b exp=1/00000000/%h req=0", inst_valid, inst_pc, inst, ifc.imem_req, TAG);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (ifc.imem_addr !== 32'h4 || ifc.imem_req !== 1'b1) begin
      n_err++; $display("FAIL dly_next_addr got=%h exp=00000004", ifc.imem_addr);
    end
  endtask

  task automatic test_stall_hold;
    test_reset();
    tick(1'b1, 32'h0000_000C, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC || inst !== (32'hC ^ TAG) || ifc.imem_req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold k=%0d got=%b/%h/%h req=%b exp=1/0000000c", k, inst_valid, inst_pc, inst, ifc.imem_req);
      end
      tick(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
    end
    tick(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    n_vec++; if (ifc.imem_addr !== 32'h80 || ifc.imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_branch got=%h/%b/%b exp=00000080/1/0", ifc.imem_addr, ifc.imem_req, inst_valid);
    end
  endtask

  task automatic test_drain;
    test_reset();
    tick(1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (ifc.imem_addr !== 32'h20 || ifc.imem_req !== 1'b1) begin
        n_err++; $display("FAIL drain_stale k=%0d got=%h/%b exp=00000020/1", k, ifc.imem_addr, ifc.imem_req);
      end
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (ifc.imem_addr !== 32'h200 || ifc.imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_redirect got=%h/%b/%b exp=00000200/1/0", ifc.imem_addr, ifc.imem_req, inst_valid);
    end
  endtask

  task automatic test_wrap;
    test_reset();
    tick(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_inst got=%b/%h exp=1/fffffffc", inst_valid, inst_pc);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (ifc.imem_addr !== 32'h0 || ifc.imem_req !== 1'b1) begin
      n_err++; $display("FAIL wrap_addr got=%h exp=00000000", ifc.imem_addr);
    end
    tick(1'b1, 32'h0000_0103, 1'b0, 1'b1, 1'b0);
    n_vec++; if (ifc.imem_addr !== 32'h100) begin
      n_err++; $display("FAIL align_addr got=%h exp=00000100", ifc.imem_addr);
    end
  endtask

  task automatic test_reset_in_drain;
    test_reset();
    tick(1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_reset got=%b/%h/%b exp=1/00000000/0", ifc.imem_req, ifc.imem_addr, inst_valid);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_err++; $display("FAIL drain_reset_fetch got=%b/%h exp=1/00000000", inst_valid, inst_pc);
    end
  endtask

  task automatic test_random;
    logic        mux, stl, rdy, rst;
    logic [31:0] tgt;
    logic        was_waiting;
    logic [31:0] prev_addr;
    test_reset();
    was_waiting = 1'b0;
    prev_addr   = 32'h0;
    for (int k = 0; k < 400; k++) begin
      n_vec++; if (ifc.imem_req !== !m_hold) begin
        n_err++; $display("FAIL rnd_req k=%0d got=%b exp=%b", k, ifc.imem_req, !m_hold);
      end
      if (!m_hold) begin
        n_vec++; if (ifc.imem_addr !== m_pc) begin
          n_err++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, ifc.imem_addr, m_pc);
        end
      end
      n_vec++; if (inst_valid !== m_hold) begin
        n_err++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, inst_valid, m_hold);
      end
      if (m_hold) begin
        n_vec++; if (inst !== m_inst || inst_pc !== m_inst_pc) begin
          n_err++; $display("FAIL rnd_inst k=%0d got=%h@%h exp=%h@%h", k, inst, inst_pc, m_inst, m_inst_pc);
        end
      end
      if (was_waiting) begin
        n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== prev_addr) begin
          n_err++; $display("FAIL rnd_protocol k=%0d got=%b/%h exp=1/%h", k, ifc.imem_req, ifc.imem_addr, prev_addr);
        end
      end
      mux = ($urandom_range(0, 99) < 15);
      stl = ($urandom_range(0, 99) < 40);
      rdy = ($urandom_range(0, 99) < 50);
      rst = ($urandom_range(0, 99) < 2);
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = {28'hFFF_FFFF, tgt[3:0]};
      was_waiting = !m_hold && !rdy && !rst;
      prev_addr   = m_pc;
      tick(mux, tgt, stl, rdy, rst);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    pcMux = 1'b0;
    stall = 1'b0;
    branch_target  = 32'h0;
    ifc.imem_ready = 1'b0;
    m_rtgt = 32'h0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_delayed_ready();
    test_stall_hold();
    test_drain();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
